// File: rtl/and_op_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the AND-operation scheduler.
// Node indices carry the complement flag in bit 0, so ONE is the negation of ZERO.
package and_op_scheduler_pkg;

    localparam int unsigned INDEX_W = 30;

    localparam logic [INDEX_W-1:0] BDD_ZERO     = 30'h0000_0000;
    localparam logic [INDEX_W-1:0] BDD_ONE      = 30'h0000_0001;
    localparam logic [INDEX_W-1:0] EQUAL_NEGATE = 30'h0000_0001;

    typedef enum logic [2:0] {
        SchIdle  = 3'd0,
        SchCheck = 3'd1,
        SchIssue = 3'd2,
        SchWait  = 3'd3,
        SchResp  = 3'd4
    } sch_state_e;

    // True when a and b name the same node with opposite polarity.
    function automatic logic is_negation(input logic [INDEX_W-1:0] a,
                                         input logic [INDEX_W-1:0] b);
        return (a ^ b) == EQUAL_NEGATE;
    endfunction

endpackage

// File: rtl/and_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module and_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [TAG_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               any_o
);

    always_comb begin
        logic [TAG_W-1:0] idx;
        idx     = '0;
        grant_o = '0;
        tag_o   = '0;
        any_o   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = TAG_W'((32'(rr_ptr_i) + k) % NUM_REQ);
            if (!any_o && req_valid_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                tag_o        = idx;
            end
        end
    end

endmodule

// File: rtl/and_terminal_case.sv
// Terminal-case evaluator for f AND g: resolves the trivial identities without recursion.
module and_terminal_case
    import and_op_scheduler_pkg::*;
(
    input  logic [INDEX_W-1:0] f_i,
    input  logic [INDEX_W-1:0] g_i,
    output logic               hit_o,
    output logic [INDEX_W-1:0] result_o
);

    always_comb begin
        hit_o    = 1'b1;
        result_o = BDD_ZERO;
        if (f_i == BDD_ZERO || g_i == BDD_ZERO) begin
            result_o = BDD_ZERO;
        end else if (f_i == BDD_ONE) begin
            result_o = g_i;
        end else if (g_i == BDD_ONE) begin
            result_o = f_i;
        end else if (f_i == g_i) begin
            result_o = f_i;
        end else if (is_negation(f_i, g_i)) begin
            result_o = BDD_ZERO;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/and_op_scheduler.sv
// Shares one AND terminal-case unit among NUM_REQ requesters; misses go downstream
// in canonical operand order and tagged responses are routed back to their owner.
module and_op_scheduler
    import and_op_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*INDEX_W-1:0] req_f,
    input  logic [NUM_REQ*INDEX_W-1:0] req_g,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [INDEX_W-1:0]         rsp_result,
    output logic                       rsp_terminal,
    output logic                       miss_valid,
    output logic [INDEX_W-1:0]         miss_f,
    output logic [INDEX_W-1:0]         miss_g,
    output logic [TAG_W-1:0]           miss_tag,
    input  logic                       miss_ready,
    input  logic                       miss_rsp_valid,
    input  logic [INDEX_W-1:0]         miss_rsp_result,
    input  logic [TAG_W-1:0]           miss_rsp_tag,
    output logic [STAT_W-1:0]          stat_hits,
    output logic [STAT_W-1:0]          stat_misses
);

    sch_state_e         state_q, state_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [INDEX_W-1:0] f_q, f_d;
    logic [INDEX_W-1:0] g_q, g_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] result_q, result_d;
    logic               terminal_q, terminal_d;
    logic [STAT_W-1:0]  hits_q, hits_d;
    logic [STAT_W-1:0]  misses_q, misses_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [TAG_W-1:0]   pick_tag;
    logic               pick_any;
    logic               term_hit;
    logic [INDEX_W-1:0] term_result;

    logic [INDEX_W-1:0] req_f_arr [NUM_REQ];
    logic [INDEX_W-1:0] req_g_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_f_arr[i] = req_f[i*INDEX_W +: INDEX_W];
        assign req_g_arr[i] = req_g[i*INDEX_W +: INDEX_W];
    end

    and_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .tag_o       (pick_tag),
        .any_o       (pick_any)
    );

    and_terminal_case u_term (
        .f_i      (f_q),
        .g_i      (g_q),
        .hit_o    (term_hit),
        .result_o (term_result)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        f_d        = f_q;
        g_d        = g_q;
        tag_d      = tag_q;
        result_d   = result_q;
        terminal_d = terminal_q;
        hits_d     = hits_q;
        misses_d   = misses_q;
        req_ready  = '0;
        rsp_valid  = '0;
        miss_valid = 1'b0;

        unique case (state_q)
            SchIdle: begin
                if (pick_any) begin
                    req_ready = pick_grant;
                    f_d       = req_f_arr[pick_tag];
                    g_d       = req_g_arr[pick_tag];
                    tag_d     = pick_tag;
                    state_d   = SchCheck;
                end
            end
            SchCheck: begin
                if (term_hit) begin
                    result_d   = term_result;
                    terminal_d = 1'b1;
                    if (hits_q != {STAT_W{1'b1}}) hits_d = hits_q + STAT_W'(1);
                    state_d    = SchResp;
                end else begin
                    // Smaller index first so the downstream table sees one canonical key.
                    if (f_q > g_q) begin
                        f_d = g_q;
                        g_d = f_q;
                    end
                    if (misses_q != {STAT_W{1'b1}}) misses_d = misses_q + STAT_W'(1);
                    state_d = SchIssue;
                end
            end
            SchIssue: begin
                miss_valid = 1'b1;
                if (miss_ready) state_d = SchWait;
            end
            SchWait: begin
                if (miss_rsp_valid && miss_rsp_tag == tag_q) begin
                    result_d   = miss_rsp_result;
                    terminal_d = 1'b0;
                    state_d    = SchResp;
                end
            end
            SchResp: begin
                rsp_valid[tag_q] = 1'b1;
                rr_ptr_d = (32'(tag_q) == NUM_REQ - 1) ? '0 : tag_q + TAG_W'(1);
                state_d  = SchIdle;
            end
            default: state_d = SchIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SchIdle;
            rr_ptr_q   <= '0;
            f_q        <= '0;
            g_q        <= '0;
            tag_q      <= '0;
            result_q   <= '0;
            terminal_q <= 1'b0;
            hits_q     <= '0;
            misses_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            f_q        <= f_d;
            g_q        <= g_d;
            tag_q      <= tag_d;
            result_q   <= result_d;
            terminal_q <= terminal_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
        end
    end

    assign rsp_result   = result_q;
    assign rsp_terminal = terminal_q;
    assign miss_f       = f_q;
    assign miss_g       = g_q;
    assign miss_tag     = tag_q;
    assign stat_hits    = hits_q;
    assign stat_misses  = misses_q;

endmodule

// File: tb/tb_and_op_scheduler.sv
// Scoreboard bench for and_op_scheduler: grants push expectations, a monitor pops and compares.
// Counters are built 8 bits wide so saturation is reachable in a short run.
module tb_and_op_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TAG_W   = 2;
    localparam int unsigned STAT_W  = 8;
    localparam int unsigned IW      = 30;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*IW-1:0] req_f;
    logic [NUM_REQ*IW-1:0] req_g;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [IW-1:0]         rsp_result;
    logic                  rsp_terminal;
    logic                  miss_valid;
    logic [IW-1:0]         miss_f;
    logic [IW-1:0]         miss_g;
    logic [TAG_W-1:0]      miss_tag;
    logic                  miss_ready;
    logic                  miss_rsp_valid;
    logic [IW-1:0]         miss_rsp_result;
    logic [TAG_W-1:0]      miss_rsp_tag;
    logic [STAT_W-1:0]     stat_hits;
    logic [STAT_W-1:0]     stat_misses;

    and_op_scheduler #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .STAT_W  (STAT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_f           (req_f),
        .req_g           (req_g),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_result      (rsp_result),
        .rsp_terminal    (rsp_terminal),
        .miss_valid      (miss_valid),
        .miss_f          (miss_f),
        .miss_g          (miss_g),
        .miss_tag        (miss_tag),
        .miss_ready      (miss_ready),
        .miss_rsp_valid  (miss_rsp_valid),
        .miss_rsp_result (miss_rsp_result),
        .miss_rsp_tag    (miss_rsp_tag),
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] onehot;
        logic [IW-1:0]      result;
        logic               term;
        int                 due;
        int                 tag;
    } rsp_exp_t;

    typedef struct {
        logic [IW-1:0]    f;
        logic [IW-1:0]    g;
        logic [TAG_W-1:0] tag;
        int               due;
    } miss_exp_t;

    rsp_exp_t  rsp_q[$];
    miss_exp_t miss_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int model_rr = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int n_grants = 0;
    int req_mode = 0;          // 0 manual, 1 random, 2 continuous hits
    bit ds_auto = 1'b0;
    bit ds_pending = 1'b0;
    int ds_delay = 0;
    bit ds_bogus = 1'b0;
    int ds_tag = 0;
    bit spacing_chk = 1'b0;
    int last_gi = -1;
    int last_grant_cyc = 0;
    logic [NUM_REQ-1:0] granted = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AND identities: x&0=0, 1&x=x, x&x=x, x&~x=0 (negation toggles bit 0).
    function automatic bit model_and(input logic [IW-1:0] f, input logic [IW-1:0] g,
                                     output logic [IW-1:0] r);
        r = '0;
        if (f == 0 || g == 0) return 1'b1;
        if (f == 1) begin r = g; return 1'b1; end
        if (g == 1) begin r = f; return 1'b1; end
        if (f == g) begin r = f; return 1'b1; end
        if ((f ^ g) == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v == (1 << STAT_W) - 1) ? v : v + 1;
    endfunction

    task automatic set_req(input int i, input logic [IW-1:0] f, input logic [IW-1:0] g);
        req_f[i*IW +: IW] = f;
        req_g[i*IW +: IW] = g;
        req_valid[i]      = 1'b1;
    endtask

    function automatic logic [IW-1:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return IW'($urandom_range(0, 7));
        return IW'($urandom);
    endfunction

    task automatic new_rand(input int i);
        logic [IW-1:0] f, g, t;
        f = rand_operand();
        case ($urandom_range(0, 5))
            0: g = '0;
            1: g = IW'(1);
            2: g = f;
            3: g = f ^ IW'(1);
            default: g = rand_operand();
        endcase
        if ($urandom_range(0, 1) == 1) begin t = f; f = g; g = t; end
        set_req(i, f, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_q.delete();
        miss_q.delete();
        model_rr   = 0;
        exp_hits   = 0;
        exp_misses = 0;
        ds_pending = 1'b0;
        granted    = '0;
        req_valid  = '0;
        req_mode   = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = (req_valid == '0) && (rsp_q.size() == 0) && (miss_q.size() == 0)
                   && !ds_pending;
        end
        check("drain", 64'(done), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_handshake(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = ds_pending;
        end
        check("handshake_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_miss_valid"}, 64'(miss_valid), 64'(0));
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
        check({tag, "_rsp_terminal"}, 64'(rsp_terminal), 64'(0));
        check({tag, "_miss_f"}, 64'(miss_f), 64'(0));
        check({tag, "_miss_g"}, 64'(miss_g), 64'(0));
        check({tag, "_miss_tag"}, 64'(miss_tag), 64'(0));
        check({tag, "_stat_hits"}, 64'(stat_hits), 64'(0));
        check({tag, "_stat_misses"}, 64'(stat_misses), 64'(0));
    endtask

    // Monitor: predicts grants, pushes expectations, pops on every DUT output event.
    initial begin
        int gi, idx;
        bit prev_miss_valid;
        logic [IW-1:0] f, g, r;
        rsp_exp_t re;
        miss_exp_t me;
        prev_miss_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_miss_valid = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    gi = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        idx = (model_rr + k) % NUM_REQ;
                        if (gi < 0 && req_valid[idx]) gi = idx;
                    end
                    check("grant", 64'(req_ready), (gi < 0) ? 64'(0) : 64'(1) << gi);
                    if (gi >= 0) begin
                        n_grants++;
                        if (spacing_chk) begin
                            if (last_gi >= 0) begin
                                check("grant_spacing", 64'(cyc - last_grant_cyc), 64'(3));
                                check("rr_order", 64'(gi), 64'((last_gi + 1) % NUM_REQ));
                            end
                            last_gi = gi;
                            last_grant_cyc = cyc;
                        end
                        f = req_f[gi*IW +: IW];
                        g = req_g[gi*IW +: IW];
                        if (model_and(f, g, r)) begin
                            rsp_q.push_back('{onehot: NUM_REQ'(1 << gi), result: r, term: 1'b1,
                                              due: cyc + 2, tag: gi});
                            exp_hits = sat_inc(exp_hits);
                        end else begin
                            miss_q.push_back('{f: (f < g) ? f : g, g: (f < g) ? g : f,
                                               tag: TAG_W'(gi), due: cyc + 2});
                            exp_misses = sat_inc(exp_misses);
                        end
                        granted[gi] = 1'b1;
                    end
                end
                if (rsp_valid != '0) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        re = rsp_q.pop_front();
                        check("rsp_valid", 64'(rsp_valid), 64'(re.onehot));
                        check("rsp_result", 64'(rsp_result), 64'(re.result));
                        check("rsp_terminal", 64'(rsp_terminal), 64'(re.term));
                        check("rsp_cycle", 64'(cyc), 64'(re.due));
                        model_rr = (re.tag + 1) % NUM_REQ;
                    end
                end
                if (miss_valid) begin
                    if (miss_q.size() == 0) begin
                        check("miss_unexpected", 64'(miss_valid), 64'(0));
                    end else begin
                        me = miss_q[0];
                        if (!prev_miss_valid) check("miss_cycle", 64'(cyc), 64'(me.due));
                        check("miss_f", 64'(miss_f), 64'(me.f));
                        check("miss_g", 64'(miss_g), 64'(me.g));
                        check("miss_tag", 64'(miss_tag), 64'(me.tag));
                        if (miss_ready) begin
                            void'(miss_q.pop_front());
                            ds_pending = 1'b1;
                            ds_tag     = int'(me.tag);
                            ds_delay   = $urandom_range(0, 3);
                            ds_bogus   = 1'($urandom_range(0, 1));
                        end
                    end
                end
                prev_miss_valid = miss_valid;
            end
        end
    end

    // Requester driver: retires granted requests and generates new ones per mode.
    initial begin
        req_valid = '0;
        req_f     = '0;
        req_g     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (granted[i]) begin
                    granted[i] = 1'b0;
                    if (req_mode == 2) set_req(i, IW'(1), rand_operand());
                    else req_valid[i] = 1'b0;
                end else if (req_mode == 1) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) new_rand(i);
                    else if (req_valid[i] && $urandom_range(0, 40) == 0) req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Downstream model: random backpressure, random latency, occasional foreign-tag reply.
    initial begin
        logic [IW-1:0] res;
        miss_ready      = 1'b0;
        miss_rsp_valid  = 1'b0;
        miss_rsp_result = '0;
        miss_rsp_tag    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ds_auto) begin
                miss_rsp_valid = 1'b0;
                miss_ready     = ($urandom_range(0, 2) != 0);
                if (ds_pending && !reset) begin
                    if (ds_delay > 0) begin
                        ds_delay--;
                    end else if (ds_bogus) begin
                        miss_rsp_valid  = 1'b1;
                        miss_rsp_tag    = TAG_W'((ds_tag + 1 + int'($urandom_range(0, NUM_REQ - 2)))
                                                 % NUM_REQ);
                        miss_rsp_result = IW'($urandom);
                        ds_bogus        = 1'b0;
                    end else begin
                        res             = IW'($urandom);
                        miss_rsp_valid  = 1'b1;
                        miss_rsp_tag    = TAG_W'(ds_tag);
                        miss_rsp_result = res;
                        rsp_q.push_back('{onehot: NUM_REQ'(1 << ds_tag), result: res, term: 1'b0,
                                          due: cyc + 1, tag: ds_tag});
                        ds_pending = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_rsp(input int tag, input logic [IW-1:0] res, input bit expect_it);
        miss_rsp_valid  = 1'b1;
        miss_rsp_tag    = TAG_W'(tag);
        miss_rsp_result = res;
        if (expect_it) begin
            rsp_q.push_back('{onehot: NUM_REQ'(1 << tag), result: res, term: 1'b0,
                              due: cyc + 1, tag: tag});
        end
        @(posedge clk);
        #1 miss_rsp_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Terminal hit: ONE & 0x123 on requester 2.
        set_req(2, IW'(1), IW'('h123));
        wait_drain(50);
        check("stat_hits_one", 64'(stat_hits), 64'(1));

        // Miss with a 5-cycle downstream stall.
        miss_ready = 1'b0;
        set_req(0, IW'('h500), IW'('h200));
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = miss_valid;
        end
        check("stall_seen", 64'(seen), 64'(1));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_valid", 64'(miss_valid), 64'(1));
            check("stall_f", 64'(miss_f), 64'('h200));
            check("stall_g", 64'(miss_g), 64'('h500));
            check("stall_tag", 64'(miss_tag), 64'(0));
        end
        @(posedge clk);
        #1 miss_ready = 1'b1;
        wait_handshake(5);
        miss_ready = 1'b0;
        ds_pending = 1'b0;
        send_rsp(0, IW'('h777), 1'b1);
        wait_drain(20);
        check("stat_misses_one", 64'(stat_misses), 64'(1));

        // Foreign tag is dropped while waiting on requester 1.
        miss_ready = 1'b1;
        set_req(1, IW'('h300), IW'('h100));
        wait_handshake(20);
        miss_ready = 1'b0;
        ds_pending = 1'b0;
        send_rsp(3, IW'('hBAD), 1'b0);
        send_rsp(1, IW'('h4242), 1'b1);
        wait_drain(20);

        // All requesters continuously valid with hits.
        last_gi     = -1;
        spacing_chk = 1'b1;
        req_mode    = 2;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, IW'(1), rand_operand());
        repeat (40) @(posedge clk);
        #1;
        spacing_chk = 1'b0;
        req_mode    = 0;
        wait_drain(100);

        // Randomised traffic against the downstream model.
        ds_auto  = 1'b1;
        req_mode = 1;
        repeat (3000) @(posedge clk);
        #1 req_mode = 0;
        wait_drain(1000);
        ds_auto    = 1'b0;
        miss_ready = 1'b0;
        @(negedge clk);
        check("rand_stat_hits", 64'(stat_hits), 64'(exp_hits));
        check("rand_stat_misses", 64'(stat_misses), 64'(exp_misses));
        @(posedge clk);
        #1;

        // Counter saturation.
        do_reset();
        @(negedge clk);
        check("sat_start_hits", 64'(stat_hits), 64'(0));
        @(posedge clk);
        #1 n_grants = 0;
        req_mode = 2;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, IW'(1), rand_operand());
        for (int n = 0; n < 4000 && n_grants < (1 << STAT_W) + 3; n++) @(posedge clk);
        #1 req_mode = 0;
        check("sat_ops_done", 64'(n_grants >= (1 << STAT_W) + 3), 64'(1));
        wait_drain(100);
        @(negedge clk);
        check("sat_hits", 64'(stat_hits), 64'((1 << STAT_W) - 1));
        check("sat_misses", 64'(stat_misses), 64'(0));
        @(posedge clk);
        #1;

        // Reset while waiting on downstream; late reply must be ignored.
        miss_ready = 1'b1;
        set_req(3, IW'('h600), IW'('h400));
        wait_handshake(20);
        miss_ready = 1'b0;
        @(posedge clk);
        #1 do_reset();
        send_rsp(3, IW'('h999), 1'b0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        check_reset_outputs("post_reset");

        check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        check("miss_q_empty", 64'(miss_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/and_op_scheduler.md
# and_op_scheduler

Shares one `AndTerminalCase` unit among `NUM_REQ` requesters, such as apply-engine recursion slots, using a round-robin arbiter. Operations that hit a terminal case are answered locally. Misses are canonicalised (operand order) and forwarded to the downstream recursion/computed-table path; the tagged response is routed back to the owner. One operation is in flight at a time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TAG_W`, 2: requester-id width, equal to clog2(`NUM_REQ`).
- `STAT_W`, 16: width of the statistics counters.

Ports (index width is `` `INDEX_DEF `` = 30 bits):
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_f` in NUM_REQ*30: operand f per requester, packed with requester i in bits [30i+29:30i].
- `req_g` in NUM_REQ*30: operand g per requester, same packing.
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `rsp_valid` out NUM_REQ: one-hot one-cycle result strobe.
- `rsp_result` out 30: result, meaningful only while any `rsp_valid` bit is high.
- `rsp_terminal` out 1: high when the result came from a terminal case.
- `miss_valid` out 1: request to downstream.
- `miss_f`, `miss_g` out 30 each: canonical operands.
- `miss_tag` out TAG_W: owning requester id.
- `miss_ready` in 1: downstream accept.
- `miss_rsp_valid` in 1: downstream result valid.
- `miss_rsp_result` in 30: downstream result.
- `miss_rsp_tag` in TAG_W: downstream result tag.
- `stat_hits`, `stat_misses` out STAT_W: saturating counters.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first requester with `req_valid` high, searching upward from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - Pulse that requester's `req_ready`, latch f, g and the tag, then go to CHECK.
  - With no valid requester, stay in IDLE.
- CHECK:
  - The `AndTerminalCase` unit evaluates the latched f and g.
  - On `hit`: latch the result, set the terminal flag, increment `stat_hits`, go to RESP.
  - On a miss: swap the operands if f > g (unsigned) so that `miss_f` ≤ `miss_g`, increment `stat_misses`, go to ISSUE.
- ISSUE:
  - Hold `miss_valid`, `miss_f`, `miss_g` and `miss_tag` stable until `miss_ready` is high.
  - On the cycle `miss_valid && miss_ready` go to WAIT.
- WAIT:
  - On `miss_rsp_valid` with `miss_rsp_tag` equal to the latched tag: latch `miss_rsp_result`, clear the terminal flag, go to RESP.
  - A response with a mismatched tag is dropped and the block stays in WAIT.
- RESP:
  - Drive `rsp_valid[tag]` for exactly one cycle, along with `rsp_result` and `rsp_terminal`.
  - Set `rr_ptr` to (tag+1) mod `NUM_REQ`, then go to IDLE.
- `miss_rsp_valid` is ignored in every state except WAIT.
- Counters saturate at all-ones and do not wrap.
- On a simultaneous hit and miss-count event, only one counter increments per operation by construction.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, all `req_ready`/`rsp_valid` bits 0, `miss_valid`=0, `rsp_result`=0, `rsp_terminal`=0, `miss_f`/`miss_g`/`miss_tag`=0, counters 0.
- Hit latency: accept at cycle T, `rsp_valid` at T+2.
- Miss latency: accept at T, `miss_valid` first high at T+2. A downstream response captured at cycle W gives `rsp_valid` at W+1.
- Back-to-back: the next grant can occur at the cycle after RESP. Minimum spacing for hits is 3 cycles per operation.
- Requesters must hold `req_valid`, `req_f` and `req_g` until they see `req_ready`. Deasserting before the grant is allowed and simply withdraws the request.
- Downstream must not return `miss_rsp_valid` in the same cycle as the ISSUE handshake. The earliest legal response is the following cycle.
- Reset mid-operation abandons the operation: no `rsp_valid`, and any late downstream response is ignored because the block is in IDLE.
- Downstream `miss_ready` is allowed to stay low indefinitely. The block stalls in ISSUE with its outputs stable.

## Structure
- Shared `Constants.v` holds `` `INDEX_DEF ``, `` `BDD_ZERO ``, `` `BDD_ONE ``, `` `EQUAL_NEGATE ``, plus new state-encoding defines `` `SCH_IDLE `` .. `` `SCH_RESP `` (3 bits).
- The block instantiates the existing `AndTerminalCase` unit on the latched operands.
- One natural sub-module is `and_rr_picker`: combinational, `req_valid` plus `rr_ptr` in, one-hot grant plus encoded tag out.

## Test plan
- `NUM_REQ`=4, only req 2 valid with f=`` `BDD_ONE `` and g=0x123: `req_ready`=4'b0100 at T, `rsp_valid`=4'b0100 at T+2, `rsp_result`=0x123, `rsp_terminal`=1, `stat_hits`=1.
- Req 0 with f=0x500, g=0x200 (miss): `miss_f`=0x200, `miss_g`=0x500, `miss_tag`=0. Hold `miss_ready` low for 5 cycles and check `miss_valid` and the operands stay stable. Reply 0x777 with tag 0: `rsp_valid[0]` one cycle later, `rsp_result`=0x777, `rsp_terminal`=0.
- All 4 requesters continuously valid with terminal operations: grant order is 0,1,2,3,0,…, with each grant 3 cycles apart.
- In WAIT (tag 1), send a response with tag 3 and then one with tag 1: the first is dropped and the second produces `rsp_valid[1]`.
- Assert `reset` while in WAIT, then send `miss_rsp_valid`: no `rsp_valid`, all outputs at reset values, counters 0.
- Issue 2^16+3 terminal hits with `STAT_W`=16: `stat_hits` saturates at 0xFFFF.
